lcd_line_writer: RTL and testbench

Write-only HD44780 character-LCD driver that serves the `print`/`available` handshake used by the game top level. On reset it runs the controller power-on initialisation. After that it accepts a 16-character top line and a 16-character bottom line and writes all 32 characters to the panel in 8-bit mode. It is the panel-side end of the top level's display interface and drives the LCD pins directly.

---
 rtl/lcd_line_writer_pkg.sv | 80 ++++++++
 rtl/lcd_line_writer_byte.sv | 105 ++++++++++
 rtl/lcd_line_writer.sv | 136 +++++++++++++
 tb/tb_lcd_line_writer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_line_writer_pkg.sv
// Shared definitions for the HD44780 line writer: command bytes, FSM encodings
// and the helpers that map a sequence index onto the byte to send.
package lcd_line_writer_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int         CNT_W           = 22;
  localparam logic [5:0] INIT_LAST_IDX   = 6'd3;
  localparam logic [5:0] LINE2_IDX       = 6'd17;
  localparam logic [5:0] SCREEN_LAST_IDX = 6'd33;

  typedef enum logic [1:0] {
    MAIN_POWERUP = 2'd0,
    MAIN_INIT    = 2'd1,
    MAIN_IDLE    = 2'd2,
    MAIN_WRITE   = 2'd3
  } main_state_e;

  typedef enum logic [1:0] {
    BW_IDLE  = 2'd0,
    BW_SETUP = 2'd1,
    BW_PULSE = 2'd2,
    BW_WAIT  = 2'd3
  } bw_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_wait;
  } lcd_byte_t;

  function automatic lcd_byte_t init_entry(input logic [5:0] idx);
    lcd_byte_t e;
    e.rs        = 1'b0;
    e.long_wait = 1'b0;
    case (idx)
      6'd0:    e.data = CMD_FUNC_SET;
      6'd1:    e.data = CMD_DISP_ON;
      6'd2: begin
        e.data      = CMD_CLEAR;
        e.long_wait = 1'b1;
      end
      6'd3:    e.data = CMD_ENTRY;
      default: e.data = CMD_ENTRY;
    endcase
    return e;
  endfunction

  // Column 0 lives in the top byte of each line, so the slice walks downwards.
  function automatic lcd_byte_t screen_entry(input logic [5:0]   idx,
                                             input logic [127:0] top,
                                             input logic [127:0] bot);
    lcd_byte_t  e;
    logic [3:0] col_sel;
    e.rs        = 1'b1;
    e.long_wait = 1'b0;
    e.data      = 8'h00;
    col_sel     = 4'd0;
    if (idx == 6'd0) begin
      e.rs   = 1'b0;
      e.data = CMD_LINE1;
    end else if (idx < LINE2_IDX) begin
      col_sel = 4'(6'd16 - idx);
      e.data  = top[{col_sel, 3'b000} +: 8];
    end else if (idx == LINE2_IDX) begin
      e.rs   = 1'b0;
      e.data = CMD_LINE2;
    end else begin
      col_sel = 4'(6'd33 - idx);
      e.data  = bot[{col_sel, 3'b000} +: 8];
    end
    return e;
  endfunction

endpackage

// File: rtl/lcd_line_writer_byte.sv
// Single HD44780 bus write: setup, enable strobe, then execution wait.
// done is high during the final wait cycle so the next byte can start without a gap.
module lcd_byte_writer
  import lcd_line_writer_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 25,
  parameter int EXEC_CYC  = 2500,
  parameter int CLEAR_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_regsel,
  output logic [7:0] lcd_data,
  output logic       lcd_enable,
  output logic       done
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

  bw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             long_q, long_d;
  logic             cnt_last_s;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BW_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      long_q  <= long_d;
    end
  end

  // Terminal count for the phase currently in progress.
  always_comb begin
    cnt_last_s = 1'b0;
    case (state_q)
      BW_SETUP: cnt_last_s = (cnt_q == SETUP_LAST);
      BW_PULSE: cnt_last_s = (cnt_q == PULSE_LAST);
      BW_WAIT:  cnt_last_s = (cnt_q == (long_q ? CLEAR_LAST : EXEC_LAST));
      default:  cnt_last_s = 1'b0;
    endcase
  end

  // Phase sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BW_IDLE:  state_d = start      ? BW_SETUP : BW_IDLE;
      BW_SETUP: state_d = cnt_last_s ? BW_PULSE : BW_SETUP;
      BW_PULSE: state_d = cnt_last_s ? BW_WAIT  : BW_PULSE;
      BW_WAIT:  state_d = cnt_last_s ? BW_IDLE  : BW_WAIT;
      default:  state_d = BW_IDLE;
    endcase
  end

  // Bus value is captured at start and held through the whole wait.
  always_comb begin
    rs_d   = rs_q;
    data_d = data_q;
    long_d = long_q;
    if (state_q == BW_IDLE && start) begin
      rs_d   = rs;
      data_d = data;
      long_d = long_wait;
    end else begin
      rs_d   = rs_q;
      data_d = data_q;
      long_d = long_q;
    end
    if (state_q == BW_IDLE || state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    en_d = (state_d == BW_PULSE);
  end

  assign done       = (state_q == BW_WAIT) && cnt_last_s;
  assign lcd_regsel = rs_q;
  assign lcd_data   = data_q;
  assign lcd_enable = en_q;

endmodule

// File: rtl/lcd_line_writer.sv
// HD44780 two-line character LCD driver: power-on init, then 34-byte screen
// refreshes on each accepted print request.
module lcd_line_writer
  import lcd_line_writer_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 25,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 100000,
  parameter int POWERUP_CYC = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         print,
  input  logic [127:0] topline,
  input  logic [127:0] bottomline,
  output logic         available,
  output logic [7:0]   lcd_data,
  output logic         lcd_regsel,
  output logic         lcd_read,
  output logic         lcd_enable
);

  localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);

  main_state_e      state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pu_cnt_q, pu_cnt_d;
  logic [127:0]     top_q, top_d;
  logic [127:0]     bot_q, bot_d;
  logic             avail_q, avail_d;

  lcd_byte_t        entry_s;
  logic             start_s;
  logic             bw_done_s;
  logic             last_idx_s;

  // Main sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MAIN_POWERUP;
      idx_q    <= 6'd0;
      busy_q   <= 1'b0;
      pu_cnt_q <= '0;
      top_q    <= 128'd0;
      bot_q    <= 128'd0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      pu_cnt_q <= pu_cnt_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      avail_q  <= avail_d;
    end
  end

  // Main FSM transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_POWERUP: state_d = (pu_cnt_q == POWERUP_LAST) ? MAIN_INIT : MAIN_POWERUP;
      MAIN_INIT:    state_d = (bw_done_s && last_idx_s) ? MAIN_IDLE : MAIN_INIT;
      MAIN_IDLE:    state_d = print ? MAIN_WRITE : MAIN_IDLE;
      MAIN_WRITE:   state_d = (bw_done_s && last_idx_s) ? MAIN_IDLE : MAIN_WRITE;
      default:      state_d = MAIN_POWERUP;
    endcase
  end

  // Sequence bookkeeping, line shadowing and the byte handed to the writer.
  always_comb begin
    if (state_q == MAIN_INIT) begin
      entry_s    = init_entry(idx_q);
      last_idx_s = (idx_q == INIT_LAST_IDX);
    end else begin
      entry_s    = screen_entry(idx_q, top_q, bot_q);
      last_idx_s = (idx_q == SCREEN_LAST_IDX);
    end

    start_s = ((state_q == MAIN_INIT) || (state_q == MAIN_WRITE)) && !busy_q;

    if (start_s) begin
      busy_d = 1'b1;
    end else if (bw_done_s) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end

    if (bw_done_s) begin
      idx_d = last_idx_s ? 6'd0 : (idx_q + 6'd1);
    end else begin
      idx_d = idx_q;
    end

    if (state_q == MAIN_POWERUP) begin
      pu_cnt_d = pu_cnt_q + CNT_W'(1);
    end else begin
      pu_cnt_d = '0;
    end

    if (state_q == MAIN_IDLE && print) begin
      top_d = topline;
      bot_d = bottomline;
    end else begin
      top_d = top_q;
      bot_d = bot_q;
    end

    avail_d = (state_d == MAIN_IDLE);
  end

  lcd_byte_writer #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .EXEC_CYC  (EXEC_CYC),
    .CLEAR_CYC (CLEAR_CYC)
  ) u_byte_writer (
    .clk        (clk),
    .rst_n      (reset),
    .start      (start_s),
    .rs         (entry_s.rs),
    .data       (entry_s.data),
    .long_wait  (entry_s.long_wait),
    .lcd_regsel (lcd_regsel),
    .lcd_data   (lcd_data),
    .lcd_enable (lcd_enable),
    .done       (bw_done_s)
  );

  assign available = avail_q;
  assign lcd_read  = 1'b0;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Scoreboard bench for lcd_line_writer: expected bus bytes are queued by the
// stimulus and popped by a monitor on every rising E strobe.
module tb_lcd_line_writer;

  localparam int SETUP_CYC   = 2;
  localparam int PULSE_CYC   = 4;
  localparam int EXEC_CYC    = 10;
  localparam int CLEAR_CYC   = 20;
  localparam int POWERUP_CYC = 50;

  // 50 + 3*17 + (1+2+4+20) = 128 edges after reset release
  localparam int INIT_AVAIL_EDGES   = 128;
  localparam int SCREEN_AVAIL_EDGES = 34 * 17;
  localparam int FIRST_EN_SAMPLE    = SETUP_CYC + 2;

  logic         clk;
  logic         reset;
  logic         print;
  logic [127:0] topline;
  logic [127:0] bottomline;
  logic         available;
  logic [7:0]   lcd_data;
  logic         lcd_regsel;
  logic         lcd_read;
  logic         lcd_enable;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q[$];
  logic       en_prev;
  int         hi_len;
  logic [8:0] cap_bus;

  lcd_line_writer #(
    .SETUP_CYC   (SETUP_CYC),
    .PULSE_CYC   (PULSE_CYC),
    .EXEC_CYC    (EXEC_CYC),
    .CLEAR_CYC   (CLEAR_CYC),
    .POWERUP_CYC (POWERUP_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .print      (print),
    .topline    (topline),
    .bottomline (bottomline),
    .available  (available),
    .lcd_data   (lcd_data),
    .lcd_regsel (lcd_regsel),
    .lcd_read   (lcd_read),
    .lcd_enable (lcd_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_screen(input logic [127:0] t, input logic [127:0] b);
    exp_q.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, t[127 - 8*c -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, b[127 - 8*c -: 8]});
  endtask

  // Monitor: compare bus on each E rise, pulse width and hold on each E fall.
  always @(negedge clk) begin
    if (!reset) begin
      en_prev <= 1'b0;
      hi_len  <= 0;
    end else begin
      if (lcd_enable && !en_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got bus 0x%0h, expected no pulse", {lcd_regsel, lcd_data});
        end else begin
          check("bus_byte", {lcd_regsel, lcd_data}, exp_q.pop_front());
        end
        check("rw_low", lcd_read, 0);
        cap_bus <= {lcd_regsel, lcd_data};
        hi_len  <= 1;
      end else if (lcd_enable) begin
        hi_len <= hi_len + 1;
      end else if (en_prev) begin
        check("pulse_width", hi_len, PULSE_CYC);
        check("bus_hold", {lcd_regsel, lcd_data}, cap_bus);
      end
      en_prev <= lcd_enable;
    end
  end

  // Reset, expect init bytes, check silence during power-up and time to available.
  task automatic reset_and_init();
    bit quiet;
    int edges;
    reset = 1'b0;
    print = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    reset = 1'b1;
    quiet = 1'b1;
    edges = -1;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e <= POWERUP_CYC && (lcd_enable || lcd_regsel || lcd_data != 8'h00 || available))
        quiet = 1'b0;
      if (available) begin
        edges = e;
        break;
      end
    end
    check("powerup_quiet", quiet, 1);
    check("init_avail_edges", edges, INIT_AVAIL_EDGES);
    check("init_queue_drained", exp_q.size(), 0);
  endtask

  // One screen from a print request; optional mid-write disturbance and held print.
  task automatic screen(input logic [127:0] t, input logic [127:0] b,
                        input bit inject, input bit hold,
                        input logic [127:0] alt_t, input logic [127:0] alt_b);
    int en_first;
    int avail_edges;
    push_screen(t, b);
    topline    = t;
    bottomline = b;
    print      = 1'b1;
    en_first    = -1;
    avail_edges = -1;
    for (int e = 1; e <= 1000; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        if (!hold) print = 1'b0;
        check("avail_drop", available, 0);
        if (inject) topline = alt_t;
      end
      if (inject && e == 100) begin
        print      = 1'b1;
        bottomline = alt_b;
      end
      if (inject && e == 101) print = 1'b0;
      if (en_first < 0 && lcd_enable) en_first = e;
      if (available) begin
        avail_edges = e - 1;
        break;
      end
    end
    check("first_enable_latency", en_first, FIRST_EN_SAMPLE);
    check("screen_avail_edges", avail_edges, SCREEN_AVAIL_EDGES);
    check("screen_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [127:0] t1, b1, t2, b2, t3, b3, alt_t, alt_b;
    int           guard;
    t1    = "Welcome to Simon";
    b1    = "Press GRN button";
    t2    = "Level 07  ready!";
    b2    = "Hold print high.";
    t3    = "Game over  score";
    b3    = "Simon says: RED!";
    alt_t = "XXXXXXXXXXXXXXXX";
    alt_b = "yyyyyyyyyyyyyyyy";

    reset      = 1'b0;
    print      = 1'b0;
    topline    = 128'd0;
    bottomline = 128'd0;
    #1;
    check("reset_available", available, 0);
    check("reset_enable", lcd_enable, 0);
    check("reset_bus", {lcd_regsel, lcd_data}, 0);

    reset_and_init();
    screen(t1, b1, 1'b0, 1'b0, alt_t, alt_b);
    repeat (5) @(negedge clk);
    check("idle_available", available, 1);

    screen(t2, b2, 1'b1, 1'b0, alt_t, alt_b);
    repeat (3) @(negedge clk);

    screen(t3, b3, 1'b0, 1'b1, alt_t, alt_b);
    screen(t1, b2, 1'b0, 1'b0, alt_t, alt_b);
    repeat (3) @(negedge clk);

    push_screen(t3, b1);
    topline    = t3;
    bottomline = b1;
    print      = 1'b1;
    @(negedge clk);
    print = 1'b0;
    guard = 0;
    while (!lcd_enable && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("enable_seen_before_reset", lcd_enable, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_enable", lcd_enable, 0);
    check("async_reset_bus", {lcd_regsel, lcd_data}, 0);
    check("async_reset_available", available, 0);
    @(negedge clk);
    reset_and_init();

    repeat (30) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
